// File: rtl/pipe_quot_recover.sv
// -----------------------------------------------------------------------------
// pipe_quot_recover
//
// Recovers the pre-multiply term of the sum-multiply pipeline by dividing the
// pipeline result F by its multiplier operand D (both unsigned, N bits).
// The divider is iterative and restoring. It produces one quotient bit per
// clock and uses a start/busy/done handshake.
//
// Timing:
//   - A start accepted in IDLE at edge k, with D != 0, produces done after
//     edge k+N.
//   - With D == 0 the result is produced at edge k and the block stays IDLE.
//   - A start seen during the done cycle is accepted. A start seen while busy
//     is dropped.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    request a division; sampled only when idle (busy = 0)
//   F [N]    dividend (pipeline result)
//   D [N]    divisor (pipeline D operand)
//   Q [N]    quotient floor(F/D), held until the next done
//   R [N]    remainder F mod D, held until the next done
//   exact    R == 0 for the current result (0 flags an inconsistent F/D pair)
//   busy     division in progress
//   done     one-cycle pulse; Q/R/exact/div_err valid
//   div_err  current result came from D == 0 (Q = all ones, R = F)
// -----------------------------------------------------------------------------
module pipe_quot_recover #(
  parameter int N = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] F,
  input  logic [N-1:0] D,
  output logic [N-1:0] Q,
  output logic [N-1:0] R,
  output logic         exact,
  output logic         busy,
  output logic         done,
  output logic         div_err
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_CALC = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Working registers.
  // The low bits of r_dividend are refilled with quotient bits as the
  // dividend bits are shifted out of the top.
  logic [N-1:0]  r_dividend;
  logic [N-1:0]  r_divisor;
  logic [N:0]    r_rem;
  logic [CW-1:0] r_count;

  // Registered results and handshake.
  logic [N-1:0]  r_q;
  logic [N-1:0]  r_r;
  logic          r_exact;
  logic          r_busy;
  logic          r_done;
  logic          r_div_err;

  // Next-state values for the registers above.
  logic [N-1:0]  w_dividend_nxt;
  logic [N-1:0]  w_divisor_nxt;
  logic [N:0]    w_rem_reg_nxt;
  logic [CW-1:0] w_count_nxt;
  logic [N-1:0]  w_q_nxt;
  logic [N-1:0]  w_r_nxt;
  logic          w_exact_nxt;
  logic          w_busy_nxt;
  logic          w_done_nxt;
  logic          w_div_err_nxt;

  // One restoring step.
  logic          w_d_zero;
  logic [N+1:0]  w_shift;
  logic [N:0]    w_trial;
  logic          w_qbit;
  logic [N:0]    w_rem_step;
  logic [N-1:0]  w_quot_step;
  logic          w_last;

  assign w_d_zero = (D == '0);

  // The partial remainder is always below the divisor, so after the shift it
  // fits in N+1 bits. The top bit of w_shift only keeps the compare honest.
  assign w_shift     = {r_rem, r_dividend[N-1]};
  assign w_qbit      = (w_shift >= {2'b00, r_divisor});
  assign w_trial     = w_shift[N:0] - {1'b0, r_divisor};
  assign w_rem_step  = w_qbit ? w_trial : w_shift[N:0];
  assign w_quot_step = {r_dividend[N-2:0], w_qbit};
  assign w_last      = (r_count == CW'(1));

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so that every
    // register samples pre-edge values, regardless of block ordering.
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default first, so that no path through the case leaves the
    // signal unassigned. Otherwise a latch would be inferred.
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start && !w_d_zero) w_state_nxt = S_CALC;
      S_CALC: if (w_last)             w_state_nxt = S_IDLE;
      default:                        w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath next-value logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_dividend_nxt = r_dividend;
    w_divisor_nxt  = r_divisor;
    w_rem_reg_nxt  = r_rem;
    w_count_nxt    = r_count;
    w_q_nxt        = r_q;
    w_r_nxt        = r_r;
    w_exact_nxt    = r_exact;
    w_div_err_nxt  = r_div_err;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_d_zero) begin
            // Division by zero is answered at once and never enters CALC.
            w_q_nxt       = '1;
            w_r_nxt       = F;
            w_exact_nxt   = 1'b0;
            w_div_err_nxt = 1'b1;
            w_done_nxt    = 1'b1;
          end else begin
            w_dividend_nxt = F;
            w_divisor_nxt  = D;
            w_rem_reg_nxt  = '0;
            w_count_nxt    = CW'(N);
            w_busy_nxt     = 1'b1;
          end
        end
      end

      S_CALC: begin
        w_dividend_nxt = w_quot_step;
        w_rem_reg_nxt  = w_rem_step;
        w_count_nxt    = r_count - CW'(1);
        if (w_last) begin
          w_q_nxt       = w_quot_step;
          w_r_nxt       = w_rem_step[N-1:0];
          w_exact_nxt   = (w_rem_step == '0);
          w_div_err_nxt = 1'b0;
          w_done_nxt    = 1'b1;
          w_busy_nxt    = 1'b0;
        end
      end

      default: begin
        w_busy_nxt = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the working registers are reset as well as the outputs.
    // A mid-CALC reset then leaves no stale operand state to analyse.
    if (!rst_n) begin
      r_dividend <= '0;
      r_divisor  <= '0;
      r_rem      <= '0;
      r_count    <= '0;
      r_q        <= '0;
      r_r        <= '0;
      r_exact    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_err  <= 1'b0;
    end else begin
      r_dividend <= w_dividend_nxt;
      r_divisor  <= w_divisor_nxt;
      r_rem      <= w_rem_reg_nxt;
      r_count    <= w_count_nxt;
      r_q        <= w_q_nxt;
      r_r        <= w_r_nxt;
      r_exact    <= w_exact_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_div_err  <= w_div_err_nxt;
    end
  end

  assign Q       = r_q;
  assign R       = r_r;
  assign exact   = r_exact;
  assign busy    = r_busy;
  assign done    = r_done;
  assign div_err = r_div_err;

endmodule

// File: tb/tb_pipe_quot_recover.sv
// -----------------------------------------------------------------------------
// tb_pipe_quot_recover
//
// Directed bench for pipe_quot_recover with N = 10.
// Inputs are driven on the falling edge and outputs are sampled on the falling
// edge, half a period away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_pipe_quot_recover;

  localparam int N = 10;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N-1:0] F;
  logic [N-1:0] D;
  logic [N-1:0] Q;
  logic [N-1:0] R;
  logic         exact;
  logic         busy;
  logic         done;
  logic         div_err;

  int n_vec;
  int n_err;

  pipe_quot_recover #(.N(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .F       (F),
    .D       (D),
    .Q       (Q),
    .R       (R),
    .exact   (exact),
    .busy    (busy),
    .done    (done),
    .div_err (div_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launches one division and waits a bounded time for done.
  // lat counts rising edges after the accepting edge, and is -1 on timeout.
  // hs_ok clears if any of these is seen:
  //   - busy is wrong during the wait;
  //   - busy is still high at done;
  //   - busy and done are high together.
  task automatic run_div(input logic [N-1:0] f, input logic [N-1:0] d,
                         output logic [N-1:0] q, output logic [N-1:0] r,
                         output logic ex, output logic er,
                         output int lat, output bit hs_ok);
    lat   = -1;
    hs_ok = 1'b1;
    q = '0; r = '0; ex = 1'b0; er = 1'b0;
    @(negedge clk);
    F = f; D = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (done === 1'b1) begin
        lat = c;
        q = Q; r = R; ex = exact; er = div_err;
        if (busy !== 1'b0) hs_ok = 1'b0;
        break;
      end
      if (d != 0 && c < N && busy !== 1'b1) hs_ok = 1'b0;
      if (d == 0 && busy !== 1'b0) hs_ok = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    start = 1'b0; F = '0; D = '0;
    rst_n = 1'b0;
    #12;
    n_vec++;
    if ({Q, R, exact, busy, done, div_err} !== '0) begin
      n_err++;
      $display("FAIL reset_hold: got Q=%0d R=%0d ex=%b busy=%b done=%b err=%b, want all 0",
               Q, R, exact, busy, done, div_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({Q, R, exact, busy, done, div_err} !== '0) begin
      n_err++;
      $display("FAIL reset_idle: got Q=%0d R=%0d ex=%b busy=%b done=%b err=%b, want all 0",
               Q, R, exact, busy, done, div_err);
    end
  endtask

  task automatic test_basic();
    logic [N-1:0] q, r;
    logic ex, er;
    int lat;
    bit hs;
    run_div(10'd600, 10'd20, q, r, ex, er, lat, hs);
    n_vec++;
    if (lat !== N) begin
      n_err++; $display("FAIL basic_latency: got %0d, want %0d", lat, N);
    end
    n_vec++;
    if (hs !== 1'b1) begin
      n_err++; $display("FAIL basic_busy: busy/done handshake wrong, got %b want 1", hs);
    end
    n_vec++;
    if ({q, r, ex, er} !== {10'd30, 10'd0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL basic_result: got Q=%0d R=%0d ex=%b err=%b, want 30 0 1 0", q, r, ex, er);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0) begin
      n_err++; $display("FAIL basic_done_pulse: done got %b after one cycle, want 0", done);
    end
  endtask

  task automatic test_extremes();
    logic [N-1:0] q, r;
    logic ex, er;
    int lat;
    bit hs;
    run_div(10'd1023, 10'd1, q, r, ex, er, lat, hs);
    n_vec++;
    if ({q, r, ex, lat} !== {10'd1023, 10'd0, 1'b1, N}) begin
      n_err++;
      $display("FAIL max_by_one: got Q=%0d R=%0d ex=%b lat=%0d, want 1023 0 1 %0d",
               q, r, ex, lat, N);
    end
    run_div(10'd7, 10'd10, q, r, ex, er, lat, hs);
    n_vec++;
    if ({q, r, ex, er} !== {10'd0, 10'd7, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL small_by_large: got Q=%0d R=%0d ex=%b err=%b, want 0 7 0 0", q, r, ex, er);
    end
  endtask

  task automatic test_div_zero();
    logic [N-1:0] q, r;
    logic ex, er;
    int lat;
    bit hs;
    run_div(10'd55, 10'd0, q, r, ex, er, lat, hs);
    n_vec++;
    if ({q, r, ex, er} !== {10'd1023, 10'd55, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL div0_result: got Q=%0d R=%0d ex=%b err=%b, want 1023 55 0 1", q, r, ex, er);
    end
    n_vec++;
    if (lat !== 0 || hs !== 1'b1) begin
      n_err++;
      $display("FAIL div0_timing: got lat=%0d hs=%b, want lat=0 with busy never high", lat, hs);
    end
    run_div(10'd9, 10'd3, q, r, ex, er, lat, hs);
    n_vec++;
    if ({q, r, ex, er, lat} !== {10'd3, 10'd0, 1'b1, 1'b0, N}) begin
      n_err++;
      $display("FAIL after_div0: got Q=%0d R=%0d ex=%b err=%b lat=%0d, want 3 0 1 0 %0d",
               q, r, ex, er, lat, N);
    end
  endtask

  task automatic test_back_to_back();
    bit seen;
    int extra;
    int gap;

    // A start pulse while busy is dropped, and mid-CALC operand changes are
    // ignored.
    @(negedge clk);
    F = 10'd100; D = 10'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    F = 10'd500; D = 10'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0; F = 10'd3; D = 10'd1;
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (done === 1'b1) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    n_vec++;
    if (!seen || {Q, R, exact} !== {10'd14, 10'd2, 1'b0}) begin
      n_err++;
      $display("FAIL b2b_latched: seen=%b Q=%0d R=%0d ex=%b, want done with 14 2 0",
               seen, Q, R, exact);
    end
    extra = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) extra++;
    end
    n_vec++;
    if (extra !== 0) begin
      n_err++; $display("FAIL b2b_no_queue: got %0d busy/done cycles, want 0", extra);
    end

    // A start held through the done cycle launches the next division.
    @(negedge clk);
    F = 10'd100; D = 10'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    F = 10'd500; D = 10'd5; start = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (done === 1'b1) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    n_vec++;
    if (!seen || {Q, R} !== {10'd14, 10'd2}) begin
      n_err++;
      $display("FAIL b2b_first: seen=%b Q=%0d R=%0d, want done with 14 2", seen, Q, R);
    end
    @(negedge clk);
    start = 1'b0;
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL b2b_accept: busy got %b after done cycle, want 1", busy);
    end
    gap = 1;
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (done === 1'b1) begin seen = 1'b1; break; end
      @(negedge clk);
      gap++;
    end
    n_vec++;
    if (!seen || gap !== N + 1 || {Q, R, exact} !== {10'd100, 10'd0, 1'b1}) begin
      n_err++;
      $display("FAIL b2b_second: seen=%b gap=%0d Q=%0d R=%0d ex=%b, want gap %0d with 100 0 1",
               seen, gap, Q, R, exact, N + 1);
    end
  endtask

  task automatic test_async_reset();
    logic [N-1:0] q, r;
    logic ex, er;
    int lat;
    bit hs;
    int stray;
    @(negedge clk);
    F = 10'd900; D = 10'd30; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL areset_pre_busy: busy got %b, want 1", busy);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({Q, R, exact, busy, done, div_err} !== '0) begin
      n_err++;
      $display("FAIL areset_immediate: got Q=%0d R=%0d ex=%b busy=%b done=%b err=%b, want all 0",
               Q, R, exact, busy, done, div_err);
    end
    stray = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done !== 1'b0) stray++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) stray++;
    end
    n_vec++;
    if (stray !== 0) begin
      n_err++; $display("FAIL areset_no_done: got %0d stray busy/done cycles, want 0", stray);
    end
    run_div(10'd900, 10'd30, q, r, ex, er, lat, hs);
    n_vec++;
    if ({q, r, ex, lat} !== {10'd30, 10'd0, 1'b1, N}) begin
      n_err++;
      $display("FAIL areset_rerun: got Q=%0d R=%0d ex=%b lat=%0d, want 30 0 1 %0d",
               q, r, ex, lat, N);
    end
  endtask

  task automatic test_sweep();
    logic [N-1:0] cur_f, cur_d;
    int gap;
    bit seen;
    int qd;
    @(negedge clk);
    cur_f = N'($urandom_range(1023, 0));
    cur_d = N'($urandom_range(1023, 1));
    F = cur_f; D = cur_d; start = 1'b1;
    gap = 0;
    for (int i = 0; i < 1000; i++) begin
      seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        gap++;
        if (done === 1'b1) begin seen = 1'b1; break; end
      end
      qd = int'(Q) * int'(cur_d) + int'(R);
      n_vec++;
      if (!seen || qd != int'(cur_f) || R >= cur_d ||
          Q !== N'(cur_f / cur_d) || exact !== (R == 0) || div_err !== 1'b0) begin
        n_err++;
        $display("FAIL sweep_%0d: F=%0d D=%0d seen=%b got Q=%0d R=%0d ex=%b err=%b, want %0d %0d",
                 i, cur_f, cur_d, seen, Q, R, exact, div_err, cur_f / cur_d, cur_f % cur_d);
        if (!seen) break;
      end
      n_vec++;
      if (gap !== N + 1) begin
        n_err++; $display("FAIL sweep_gap_%0d: got %0d cycles, want %0d", i, gap, N + 1);
      end
      gap = 0;
      cur_f = N'($urandom_range(1023, 0));
      cur_d = N'($urandom_range(1023, 1));
      F = cur_f; D = cur_d;
    end
    start = 1'b0;
    repeat (N + 4) @(negedge clk);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    start = 1'b0;
    F = '0;
    D = '0;
    test_reset();
    test_basic();
    test_extremes();
    test_div_zero();
    test_back_to_back();
    test_async_reset();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
